register_bus_arbiter: RTL
=========================

// Module: register_bus_arbiter
// PURPOSE
//  Shares one register-block access port (w_en/w_addr/w_value, r_en/r_addr/r_value/r_valid) among N_REQ requesters.
//  Requester 0 = UART command parser; others = on-chip sequencers. Buffers one write + one read per requester,
//  round-robin arbitrates, keeps one transaction in flight, routes each read response back to its originator.
// PARAMETERS
//  N_REQ       2    number of requesters (>=2)
//  ADDR_WIDTH  8    register address width
//  DATA_WIDTH  32   register data width (WORD_WIDTH*REG_WIDTH)
//  TIMEOUT     256  read-wait limit in cycles (used only with REG_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                     clock
//  i_reset_n    in   1                     asynchronous reset, active low
//  i_w_en       in   [N_REQ]               per-requester write request pulse
//  i_w_addr     in   [N_REQ] x ADDR_WIDTH  write address (unpacked array)
//  i_w_value    in   [N_REQ] x DATA_WIDTH  write data (unpacked array)
//  i_r_en       in   [N_REQ]               per-requester read request pulse
//  i_r_addr     in   [N_REQ] x ADDR_WIDTH  read address (unpacked array)
//  o_r_value    out  [N_REQ] x DATA_WIDTH  read data, valid with o_r_valid
//  o_r_valid    out  [N_REQ]               1-cycle read-response pulse to the originator
//  o_r_err      out  [N_REQ]               1-cycle pulse with o_r_valid on read timeout
//  o_busy       out  [N_REQ]               requester has a pending write or read
//  o_drop       out  [N_REQ]               1-cycle pulse: request lost (slot occupied)
//  o_w_en/o_w_addr/o_w_value  out  1/ADDR_WIDTH/DATA_WIDTH  to register block write port
//  o_r_en/o_r_addr            out  1/ADDR_WIDTH             to register block read port
//  i_r_value/i_r_valid        in   DATA_WIDTH/1             from register block read port
// BEHAVIOUR
//  Reset: all outputs 0, all slots empty, RR pointer 0, FSM IDLE. Reset mid-read discards it; no o_r_valid.
//  Capture: i_w_en[i] loads W-slot[i] (addr, data) if empty, else ignored and o_drop[i] pulses next cycle.
//   Same for i_r_en[i] into R-slot[i]. Simultaneous w_en and r_en from one requester: both captured.
//   A slot freed on the same edge as a new request for it: new request is captured, no drop.
//  o_busy[i] = W-slot[i] | R-slot[i] valid (registered view of slots).
//  Arbitration (IDLE only): scan requesters from RR pointer upward, wrapping; first with any pending slot wins.
//   Within the winner, write is served before read. Pointer <= winner+1 (mod N_REQ) after each grant.
//  FSM:
//   IDLE      -> WRITE if the winner has a write; -> RD_ISSUE if it has only a read; stays IDLE if nothing pending.
//   WRITE     o_w_en=1 for exactly 1 cycle with slot addr/data; W-slot cleared; -> IDLE
//   RD_ISSUE  o_r_en=1 for exactly 1 cycle; owner id latched; R-slot cleared; -> RD_WAIT
//   RD_WAIT   on i_r_valid: o_r_value[owner]<=i_r_value, o_r_valid[owner] pulses next cycle; -> IDLE
//  Latency: request pulse in cycle c, arbiter idle, no contention -> o_w_en/o_r_en high in cycle c+2.
//  Response: i_r_valid in cycle d -> o_r_valid[owner] high in cycle d+1. Write issue rate: 1 per 2 cycles.
//  i_r_valid outside RD_WAIT is ignored. o_r_value[i] holds its last value until the next response to i.
//  o_w_*/o_r_addr outputs are registered; addr/data hold their last value when the enable is low.
// CONFIGURATION
//  REG_ARB_TIMEOUT_EN defined: RD_WAIT counts cycles. TIMEOUT cycles with no i_r_valid -> o_r_valid[owner]
//   and o_r_err[owner] pulse together, o_r_value[owner] = all ones; -> IDLE. A late i_r_valid is ignored.
//  Not defined: RD_WAIT waits indefinitely; no counter present; o_r_err tied to 0.
// TESTING
//  1 Assert i_reset_n=0 mid-traffic -> all outputs 0 immediately; after release, no stale o_w_en or o_r_valid.
//  2 req0 write addr 0x03 data 0xDEADBEEF in cycle c -> o_w_en=1 in c+2 only, o_w_addr=0x03,
//    o_w_value=0xDEADBEEF; o_busy[0] high in c+1..c+2.
//  3 req0 and req1 write in the same cycle (ptr=0) -> req0 issued first, req1 two cycles later;
//    repeat with ptr=1 -> req1 issued first.
//  4 req1 read addr 0x05; block returns i_r_valid 1 cycle after o_r_en with 0x12345678
//    -> o_r_valid[1]=1 for 1 cycle, o_r_value[1]=0x12345678, o_r_valid[0] stays 0.
//  5 req0 writes on 2 consecutive cycles while a read is in RD_WAIT -> first held, o_drop[0] pulses once;
//    the write issues after the read completes.
//  6 With REG_ARB_TIMEOUT_EN and TIMEOUT=8, req0 read with no i_r_valid -> after 8 RD_WAIT cycles
//    o_r_valid[0]=o_r_err[0]=1 and o_r_value[0]=0xFFFFFFFF; without the macro it is still waiting at 100 cycles.

Source files
------------

// File: rtl/register_bus_arbiter.sv
// register_bus_arbiter
//   Shares one register-block access port among N_REQ requesters (requester 0
//   is the UART command parser, the rest are on-chip sequencers). Each
//   requester owns one write slot and one read slot. A round-robin arbiter
//   picks the next requester while idle. Only one transaction is in flight at
//   a time, and every read response is routed back to the requester that
//   issued it.
//
// Optional feature macro: REG_ARB_TIMEOUT_EN
//   When defined, a read that waits TIMEOUT cycles without i_r_valid ends
//   with an error response: o_r_valid and o_r_err pulse together and the
//   read data is all ones.
//   When undefined, a read waits indefinitely and o_r_err is tied to 0.
//
// Parameters
//   N_REQ       number of requesters (>= 2)
//   ADDR_WIDTH  register address width
//   DATA_WIDTH  register data width
//   TIMEOUT     read-wait limit in cycles (only used with REG_ARB_TIMEOUT_EN)
//
// Ports
//   clk, i_reset_n            clock, asynchronous active-low reset
//   i_w_en/i_w_addr/i_w_value per-requester write request pulse + payload
//   i_r_en/i_r_addr           per-requester read request pulse + address
//   o_r_value/o_r_valid       per-requester read data + 1-cycle valid pulse
//   o_r_err                   per-requester read-timeout pulse (with o_r_valid)
//   o_busy                    requester has a pending write or read slot
//   o_drop                    1-cycle pulse: a request hit an occupied slot
//   o_w_en/o_w_addr/o_w_value registered write port to the register block
//   o_r_en/o_r_addr           registered read port to the register block
//   i_r_value/i_r_valid       read response from the register block

module register_bus_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic [N_REQ-1:0]      i_w_en,
  input  logic [ADDR_WIDTH-1:0] i_w_addr  [N_REQ],
  input  logic [DATA_WIDTH-1:0] i_w_value [N_REQ],
  input  logic [N_REQ-1:0]      i_r_en,
  input  logic [ADDR_WIDTH-1:0] i_r_addr  [N_REQ],
  output logic [DATA_WIDTH-1:0] o_r_value [N_REQ],
  output logic [N_REQ-1:0]      o_r_valid,
  output logic [N_REQ-1:0]      o_r_err,
  output logic [N_REQ-1:0]      o_busy,
  output logic [N_REQ-1:0]      o_drop,
  output logic                  o_w_en,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [DATA_WIDTH-1:0] o_w_value,
  output logic                  o_r_en,
  output logic [ADDR_WIDTH-1:0] o_r_addr,
  input  logic [DATA_WIDTH-1:0] i_r_value,
  input  logic                  i_r_valid
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  // Request slots
  logic [N_REQ-1:0]      w_valid;
  logic [N_REQ-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] w_slot_addr [N_REQ];
  logic [DATA_WIDTH-1:0] w_slot_data [N_REQ];
  logic [ADDR_WIDTH-1:0] r_slot_addr [N_REQ];

  // Slot bookkeeping
  logic [N_REQ-1:0] w_free;
  logic [N_REQ-1:0] r_free;
  logic [N_REQ-1:0] w_load;
  logic [N_REQ-1:0] r_load;
  logic [N_REQ-1:0] w_drop;
  logic [N_REQ-1:0] r_drop;
  logic [N_REQ-1:0] pending;

  // Arbitration
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            grant;
  logic            timeout_hit;

  assign pending = w_valid | r_valid;
  assign o_busy  = pending;
  assign grant   = (state == IDLE) && found;

  // A slot is released by the cycle that actually issues it (WRITE or
  // RD_ISSUE), so a new request arriving on that same edge refills the slot
  // instead of being dropped.
  always_comb begin
    w_free = '0;
    r_free = '0;
    if (state == WRITE)    w_free[owner] = 1'b1;
    if (state == RD_ISSUE) r_free[owner] = 1'b1;
  end

  assign w_load = i_w_en & ~(w_valid & ~w_free);
  assign r_load = i_r_en & ~(r_valid & ~r_free);
  assign w_drop = i_w_en & w_valid & ~w_free;
  assign r_drop = i_r_en & r_valid & ~r_free;

  // Round-robin scan starting at ptr, wrapping at N_REQ.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_W'(idx);
      if (!found && pending[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  assign ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (found) state_next = w_valid[winner] ? WRITE : RD_ISSUE;
      end
      WRITE:    state_next = IDLE;
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (i_r_valid || timeout_hit) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Slot capture/release and drop reporting
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_valid <= '0;
      r_valid <= '0;
      o_drop  <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        w_slot_addr[i] <= '0;
        w_slot_data[i] <= '0;
        r_slot_addr[i] <= '0;
      end
    end else begin
      o_drop <= w_drop | r_drop;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_load[i]) begin
          w_valid[i]     <= 1'b1;
          w_slot_addr[i] <= i_w_addr[i];
          w_slot_data[i] <= i_w_value[i];
        end else if (w_free[i]) begin
          w_valid[i] <= 1'b0;
        end
        if (r_load[i]) begin
          r_valid[i]     <= 1'b1;
          r_slot_addr[i] <= i_r_addr[i];
        end else if (r_free[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // The bus enables are registered at grant time, so they are high exactly
  // during the WRITE / RD_ISSUE cycle that follows.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr       <= '0;
      owner     <= '0;
      o_w_en    <= 1'b0;
      o_w_addr  <= '0;
      o_w_value <= '0;
      o_r_en    <= 1'b0;
      o_r_addr  <= '0;
      o_r_valid <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      o_r_err   <= '0;
`endif
      for (int unsigned i = 0; i < N_REQ; i++) o_r_value[i] <= '0;
    end else begin
      o_w_en    <= 1'b0;
      o_r_en    <= 1'b0;
      o_r_valid <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      o_r_err   <= '0;
`endif
      if (grant) begin
        owner <= winner;
        ptr   <= ptr_next;
        if (w_valid[winner]) begin
          o_w_en    <= 1'b1;
          o_w_addr  <= w_slot_addr[winner];
          o_w_value <= w_slot_data[winner];
        end else begin
          o_r_en   <= 1'b1;
          o_r_addr <= r_slot_addr[winner];
        end
      end
      if (state == RD_WAIT && i_r_valid) begin
        o_r_valid[owner] <= 1'b1;
        o_r_value[owner] <= i_r_value;
      end
`ifdef REG_ARB_TIMEOUT_EN
      else if (timeout_hit) begin
        o_r_valid[owner] <= 1'b1;
        o_r_err[owner]   <= 1'b1;
        o_r_value[owner] <= '1;
      end
`endif
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt is 0 in the first RD_WAIT cycle, so the limit is TIMEOUT-1.
  assign timeout_hit = (state == RD_WAIT) && !i_r_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n)              wait_cnt <= '0;
    else if (state != RD_WAIT)   wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign o_r_err     = '0;
`endif

endmodule
